// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping modulo N.
module rr_pick import arb_pkg::*; #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic                  any,
    output logic [clog2(N)-1:0]   winner
);

    localparam int unsigned IW = clog2(N);

    int unsigned idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with bounded tenure: one registered one-hot grant,
// priority rotates after each grant, holder pre-empted after MAX_HOLD cycles.
module rr_grant_arbiter import arb_pkg::*; #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          i_request,
    output logic [N-1:0]          o_grant,
    output logic [clog2(N)-1:0]   o_grant_id,
    output logic                  o_busy,
    output logic                  o_preempt
);

    localparam int unsigned IW = clog2(N);
    localparam int unsigned CW = clog2(MAX_HOLD + 1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            pick_any;
    logic [IW-1:0]   pick_winner;
    logic            holder_req;
    logic            others_req;

    rr_pick #(.N(N)) u_pick (
        .req    (i_request),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign holder_req = |(i_request & o_grant);
    assign others_req = |(i_request & ~o_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            o_grant    <= '0;
            o_grant_id <= '0;
            o_busy     <= 1'b0;
            o_preempt  <= 1'b0;
        end else begin
            o_preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= GRANT;
                        o_grant    <= {{(N-1){1'b0}}, 1'b1} << pick_winner;
                        o_grant_id <= pick_winner;
                        o_busy     <= 1'b1;
                        cnt        <= CW'(1);
                        ptr        <= (pick_winner == IW'(N - 1)) ? '0 : pick_winner + IW'(1);
                    end else begin
                        o_grant    <= '0;
                        o_grant_id <= '0;
                        o_busy     <= 1'b0;
                        cnt        <= '0;
                    end
                end
                GRANT: begin
                    if (!holder_req) begin
                        state      <= IDLE;
                        o_grant    <= '0;
                        o_grant_id <= '0;
                        o_busy     <= 1'b0;
                        cnt        <= '0;
                    end else if (cnt < CW'(MAX_HOLD)) begin
                        cnt <= cnt + CW'(1);
                    end else if (others_req) begin
                        state      <= IDLE;
                        o_grant    <= '0;
                        o_grant_id <= '0;
                        o_busy     <= 1'b0;
                        o_preempt  <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        // Uncontested holder simply starts a fresh tenure.
                        cnt <= CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N=4, MAX_HOLD=8); observed word is
// {grant[3:0], grant_id[1:0], busy, preempt}.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] i_request;
    logic [3:0] o_grant;
    logic [1:0] o_grant_id;
    logic       o_busy;
    logic       o_preempt;
    logic [7:0] obs;

    int vectors;
    int miscompares;

    rr_grant_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_request  (i_request),
        .o_grant    (o_grant),
        .o_grant_id (o_grant_id),
        .o_busy     (o_busy),
        .o_preempt  (o_preempt)
    );

    assign obs = {o_grant, o_grant_id, o_busy, o_preempt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_request = 4'b0000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs !== 8'b0000_00_0_0) begin
            miscompares++;
            $display("FAIL reset: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [2];
        exp[0] = 8'b0010_01_1_0;
        exp[1] = 8'b0000_00_0_0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            i_request = (i == 0) ? 4'b0010 : 4'b0000;
            step();
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL single[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] g;
        logic [7:0] e;
        do_reset();
        for (int o = 0; o < 5; o++) begin
            g = 4'b0001 << (o % 4);
            e = {g, 2'(o % 4), 1'b1, 1'b0};
            i_request = 4'b1111;
            for (int c = 0; c < 2; c++) begin
                step();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL rotation owner%0d hold%0d: got %b want %b", o, c, obs, e);
                end
            end
            i_request = 4'b1111 & ~g;
            step();
            vectors++;
            if (obs !== 8'b0000_00_0_0) begin
                miscompares++;
                $display("FAIL rotation gap%0d: got %b want %b", o, obs, 8'b0000_00_0_0);
            end
        end
    endtask

    task automatic test_timeout_contention();
        do_reset();
        i_request = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            vectors++;
            if (obs !== 8'b0001_00_1_0) begin
                miscompares++;
                $display("FAIL contention hold%0d: got %b want %b", c, obs, 8'b0001_00_1_0);
            end
            if (c == 2) i_request = 4'b0101;
        end
        step();
        vectors++;
        if (obs !== 8'b0000_00_0_1) begin
            miscompares++;
            $display("FAIL contention preempt: got %b want %b", obs, 8'b0000_00_0_1);
        end
        step();
        vectors++;
        if (obs !== 8'b0100_10_1_0) begin
            miscompares++;
            $display("FAIL contention next_owner: got %b want %b", obs, 8'b0100_10_1_0);
        end
    endtask

    task automatic test_timeout_alone();
        do_reset();
        i_request = 4'b1000;
        for (int c = 1; c <= 20; c++) begin
            step();
            vectors++;
            if (obs !== 8'b1000_11_1_0) begin
                miscompares++;
                $display("FAIL alone cycle%0d: got %b want %b", c, obs, 8'b1000_11_1_0);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] req [3];
        logic [7:0] exp [3];
        req[0] = 4'b0100; exp[0] = 8'b0100_10_1_0;
        req[1] = 4'b0000; exp[1] = 8'b0000_00_0_0;
        req[2] = 4'b0011; exp[2] = 8'b0001_00_1_0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            i_request = req[i];
            step();
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_request = 4'b0100;
        step();
        vectors++;
        if (obs !== 8'b0100_10_1_0) begin
            miscompares++;
            $display("FAIL async_reset pre: got %b want %b", obs, 8'b0100_10_1_0);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 8'b0000_00_0_0) begin
            miscompares++;
            $display("FAIL async_reset immediate: got %b want %b", obs, 8'b0000_00_0_0);
        end
        i_request = 4'b1100;
        #2 rst = 1'b0;
        step();
        vectors++;
        if (obs !== 8'b0100_10_1_0) begin
            miscompares++;
            $display("FAIL async_reset restart: got %b want %b", obs, 8'b0100_10_1_0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        i_request   = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_timeout_contention();
        test_timeout_alone();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
